// File: rtl/flush_rr_arbiter.sv
// rtl/flush_rr_arbiter.sv - N-channel request arbiter with flush-hold tracking, stall generation and starvation override
module flush_rr_arbiter #(
  parameter int NUM_CHANNELS  = 4,
  parameter int ADDRESS_WIDTH = 8,
  parameter int ID_WIDTH      = 4,
  parameter int ARB_MODE      = 0,
  parameter int STARVE_LIMIT  = 8,
  localparam int CW           = $clog2(NUM_CHANNELS)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CHANNELS-1:0]           in_valid,
  input  logic [NUM_CHANNELS*ADDRESS_WIDTH-1:0] in_address,
  input  logic [NUM_CHANNELS*ID_WIDTH-1:0]  in_id,
  input  logic [NUM_CHANNELS-1:0]           in_flush,
  input  logic [NUM_CHANNELS-1:0]           in_flush_done,
  output logic [NUM_CHANNELS-1:0]           out_stall,
  input  logic                              in_ready,
  output logic                              out_valid,
  output logic [ADDRESS_WIDTH-1:0]          out_address,
  output logic [ID_WIDTH-1:0]               out_id,
  output logic [CW-1:0]                     out_choice,
  output logic [NUM_CHANNELS-1:0]           out_flush_hold,
  output logic [NUM_CHANNELS-1:0]           out_starved
);

  localparam int WW = $clog2(STARVE_LIMIT + 1);
  localparam logic [WW-1:0] LIMIT = WW'(STARVE_LIMIT);

  logic [CW-1:0]           rr_ptr;
  logic [NUM_CHANNELS-1:0] flush_hold;
  logic [NUM_CHANNELS-1:0] eligible;
  logic [NUM_CHANNELS-1:0] starved;
  logic [WW-1:0]           wait_cnt [NUM_CHANNELS];
  logic [CW-1:0]           sel;
  logic                    found;
  logic                    transfer;

  always_comb begin
    eligible = in_valid & ~in_flush & ~flush_hold;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      starved[i] = (wait_cnt[i] == LIMIT);
    end
  end

  assign out_starved    = starved;
  assign out_flush_hold = flush_hold;

  // Starved channels pre-empt the normal policy, lowest index first.
  always_comb begin
    int idx;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (!found && eligible[i] && starved[i]) begin
        sel   = CW'(i);
        found = 1'b1;
      end
    end
    if (!found) begin
      if (ARB_MODE == 0) begin
        for (int off = 0; off < NUM_CHANNELS; off++) begin
          idx = (int'(rr_ptr) + off) % NUM_CHANNELS;
          if (!found && eligible[idx]) begin
            sel   = CW'(idx);
            found = 1'b1;
          end
        end
      end else begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
          if (!found && eligible[i]) begin
            sel   = CW'(i);
            found = 1'b1;
          end
        end
      end
    end
  end

  assign transfer = in_ready & found & ~reset;

  always_comb begin
    out_valid   = 1'b0;
    out_choice  = '0;
    out_address = '0;
    out_id      = '0;
    out_stall   = {NUM_CHANNELS{1'b1}};
    if (!reset) begin
      out_valid = transfer;
      if (transfer) begin
        out_choice  = sel;
        out_address = in_address[int'(sel)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        out_id      = in_id[int'(sel)*ID_WIDTH +: ID_WIDTH];
      end
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        out_stall[i] = in_flush[i] | flush_hold[i] |
                       (in_valid[i] & ~(transfer && (sel == CW'(i))));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr     <= '0;
      flush_hold <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        wait_cnt[i] <= '0;
      end
    end else begin
      if (transfer) begin
        rr_ptr <= (sel == CW'(NUM_CHANNELS - 1)) ? '0 : sel + 1'b1;
      end
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        flush_hold[i] <= flush_hold[i] ? (in_flush[i] | ~in_flush_done[i]) : in_flush[i];
        // Flush and resource back-pressure freeze the count rather than clear it.
        if ((transfer && (sel == CW'(i))) || !in_valid[i]) begin
          wait_cnt[i] <= '0;
        end else if (in_flush[i] || flush_hold[i] || !in_ready) begin
          wait_cnt[i] <= wait_cnt[i];
        end else if (eligible[i] && (wait_cnt[i] != LIMIT)) begin
          wait_cnt[i] <= wait_cnt[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_flush_rr_arbiter.sv
// tb/tb_flush_rr_arbiter.sv - randomized check of flush_rr_arbiter in round-robin and fixed-priority builds
module tb_flush_rr_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  in_valid, in_flush, in_flush_done;
  logic [N*8-1:0] in_address;
  logic [N*4-1:0] in_id;
  logic          in_ready;

  logic [1:0]         o_valid;
  logic [1:0][N-1:0]  o_stall, o_hold, o_starved;
  logic [1:0][1:0]    o_choice;
  logic [1:0][7:0]    o_addr;
  logic [1:0][3:0]    o_id;

  int n_checks = 0;
  int n_fail   = 0;

  int m_ptr  [2];
  int m_hold [2][N];
  int m_wait [2][N];

  always #5 clk = ~clk;

  flush_rr_arbiter #(.NUM_CHANNELS(N), .ADDRESS_WIDTH(8), .ID_WIDTH(4), .ARB_MODE(0), .STARVE_LIMIT(8)) u_rr (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_address(in_address), .in_id(in_id),
    .in_flush(in_flush), .in_flush_done(in_flush_done), .out_stall(o_stall[0]), .in_ready(in_ready),
    .out_valid(o_valid[0]), .out_address(o_addr[0]), .out_id(o_id[0]), .out_choice(o_choice[0]),
    .out_flush_hold(o_hold[0]), .out_starved(o_starved[0])
  );

  flush_rr_arbiter #(.NUM_CHANNELS(N), .ADDRESS_WIDTH(8), .ID_WIDTH(4), .ARB_MODE(1), .STARVE_LIMIT(3)) u_fp (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_address(in_address), .in_id(in_id),
    .in_flush(in_flush), .in_flush_done(in_flush_done), .out_stall(o_stall[1]), .in_ready(in_ready),
    .out_valid(o_valid[1]), .out_address(o_addr[1]), .out_id(o_id[1]), .out_choice(o_choice[1]),
    .out_flush_hold(o_hold[1]), .out_starved(o_starved[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int cyc);
    reset         = (cyc == 0) || ($urandom_range(0, 99) == 0);
    in_address    = {$urandom, $urandom};
    in_id         = $urandom;
    if (cyc >= 1 && cyc <= 5) begin
      in_valid      = '1;
      in_flush      = '0;
      in_flush_done = '0;
      in_ready      = 1'b1;
    end else begin
      for (int i = 0; i < N; i++) begin
        in_valid[i]      = ($urandom_range(0, 3) != 0);
        in_flush[i]      = ($urandom_range(0, 9) == 0);
        in_flush_done[i] = ($urandom_range(0, 2) == 0);
      end
      in_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  // Reference: evaluate one cycle of arbitration per build from the rules, then advance state.
  task automatic model_cycle(input int cyc);
    for (int m = 0; m < 2; m++) begin
      int limit = (m == 0) ? 8 : 3;
      int g = -1;
      bit elig [N];
      bit xv;
      logic [N-1:0] xstall, xhold, xstarv;
      string t;
      for (int i = 0; i < N; i++) begin
        elig[i]   = in_valid[i] && !in_flush[i] && (m_hold[m][i] == 0);
        xhold[i]  = (m_hold[m][i] != 0);
        xstarv[i] = (m_wait[m][i] == limit);
      end
      for (int i = 0; i < N; i++)
        if (g < 0 && elig[i] && m_wait[m][i] == limit) g = i;
      if (g < 0) begin
        for (int off = 0; off < N; off++) begin
          int j = (m == 0) ? (m_ptr[m] + off) % N : off;
          if (g < 0 && elig[j]) g = j;
        end
      end
      xv = !reset && in_ready && (g >= 0);
      for (int i = 0; i < N; i++)
        xstall[i] = reset || in_flush[i] || xhold[i] || (in_valid[i] && !(xv && g == i));
      t = $sformatf("c%0d b%0d", cyc, m);
      check({t, " valid"},   32'(o_valid[m]),   32'(xv));
      check({t, " choice"},  32'(o_choice[m]),  xv ? 32'(g) : 32'd0);
      check({t, " address"}, 32'(o_addr[m]),    xv ? 32'((in_address >> (8 * g)) & 8'hff) : 32'd0);
      check({t, " id"},      32'(o_id[m]),      xv ? 32'((in_id >> (4 * g)) & 4'hf) : 32'd0);
      check({t, " stall"},   32'(o_stall[m]),   32'(xstall));
      check({t, " hold"},    32'(o_hold[m]),    32'(xhold));
      check({t, " starved"}, 32'(o_starved[m]), 32'(xstarv));
      if (reset) begin
        m_ptr[m] = 0;
        for (int i = 0; i < N; i++) begin
          m_hold[m][i] = 0;
          m_wait[m][i] = 0;
        end
      end else begin
        if (xv) m_ptr[m] = (g + 1) % N;
        for (int i = 0; i < N; i++) begin
          if ((xv && g == i) || !in_valid[i]) m_wait[m][i] = 0;
          else if (in_flush[i] || xhold[i] || !in_ready) m_wait[m][i] = m_wait[m][i];
          else if (elig[i] && m_wait[m][i] < limit) m_wait[m][i]++;
          if (xhold[i]) m_hold[m][i] = (in_flush[i] || !in_flush_done[i]) ? 1 : 0;
          else          m_hold[m][i] = in_flush[i] ? 1 : 0;
        end
      end
    end
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_ptr[m] = 0;
      for (int i = 0; i < N; i++) begin
        m_hold[m][i] = 0;
        m_wait[m][i] = 0;
      end
    end
    drive(0);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        check("reset valid", 32'(o_valid), 32'd0);
        check("reset stall", 32'(o_stall), 32'hff);
      end else if (cyc >= 2 && cyc <= 5) begin
        check($sformatf("rr sequence c%0d", cyc), 32'(o_choice[0]), 32'((cyc - 1) % N));
      end
      model_cycle(cyc);
      @(posedge clk);
      #1;
      drive(cyc + 1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flush_rr_arbiter.md
Name: flush_rr_arbiter

Overview:
- N-channel successor to the two-pipeline arbitration front-end.
- Accepts the output stage of NUM_CHANNELS request pipelines and selects one per cycle for the shared resource, with round-robin or fixed-priority selection.
- Owns per-channel flush-hold tracking and generates per-channel back-pressure (stall).
- Adds starvation detection with priority override, which the two-channel arbiter lacks.

Parameters:
- NUM_CHANNELS, 4, number of request channels (>=2).
- ADDRESS_WIDTH, 8, request address width.
- ID_WIDTH, 4, request ID width.
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- STARVE_LIMIT, 8, wait cycles before a channel is flagged starved (>=1).
- CW (local), $clog2(NUM_CHANNELS), channel index width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  NUM_CHANNELS  per-channel request valid
- in_address  in  NUM_CHANNELS*ADDRESS_WIDTH  packed addresses; channel i at [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
- in_id  in  NUM_CHANNELS*ID_WIDTH  packed IDs, same packing
- in_flush  in  NUM_CHANNELS  producer flush request per channel
- in_flush_done  in  NUM_CHANNELS  pipeline reports flush drained
- out_stall  out  NUM_CHANNELS  hold channel's output stage
- in_ready  in  1  shared resource can accept
- out_valid  out  1  request issued this cycle
- out_address  out  ADDRESS_WIDTH  selected address
- out_id  out  ID_WIDTH  selected ID
- out_choice  out  CW  selected channel index
- out_flush_hold  out  NUM_CHANNELS  flush-hold register state
- out_starved  out  NUM_CHANNELS  wait counter at STARVE_LIMIT

Behaviour:
- Reset (sync, one clk edge) clears rr_ptr=0, flush_hold=0 and all wait counters=0.
- While reset is high: out_valid=0, out_stall=all ones, out_choice=0, out_address=0, out_id=0.
- Flush hold per channel i:
  - If hold=0: next hold = in_flush[i].
  - If hold=1: next hold = in_flush[i] | ~in_flush_done[i].
  - in_flush_done while hold=0 is ignored.
- Eligibility: eligible[i] = in_valid[i] & ~in_flush[i] & ~flush_hold[i].
- Grant (combinational, zero latency):
  - A starved eligible channel, if any, wins; lowest index among starved.
  - Otherwise, mode 0 scans from rr_ptr upward modulo N and takes the first eligible.
  - Otherwise, mode 1 takes the lowest eligible index.
- out_valid = in_ready & (any eligible).
- Transfer occurs in a cycle where out_valid=1.
- When out_valid=0: out_choice=0, out_address=0, out_id=0.
- out_stall[i] = in_flush[i] | flush_hold[i] | (in_valid[i] & ~(grant[i] & in_ready)).
- out_stall[i] = 0 for an idle, unflushed channel, so empty pipelines keep filling.
- rr_ptr:
  - On a transfer from channel k, rr_ptr <= (k+1) mod N. Wrap from N-1 to 0.
  - rr_ptr is unchanged with no transfer, including when in_ready=0.
  - rr_ptr is updated in mode 1 but unused.
- Wait counter per channel, CW-independent width $clog2(STARVE_LIMIT+1):
  - Cleared on transfer of i or when in_valid[i]=0.
  - Holds while in_flush[i] or flush_hold[i] is set.
  - Holds while in_ready=0; stall caused by the resource is not starvation.
  - Otherwise increments when eligible[i] and not granted, saturating at STARVE_LIMIT.
- out_starved[i] = (wait[i] == STARVE_LIMIT), taken from the register.
- Simultaneous events:
  - in_flush[i] is high in the same cycle channel i would win: no grant to i, and the next eligible channel is chosen the same cycle.
  - in_flush and in_flush_done are both high with hold=1: hold stays 1.
- Reset mid-operation: any in-flight grant is dropped; no partial state is retained.

Test Plan:
1. Mode 0, N=4; apply reset, then all in_valid=1 and in_ready=1 for 5 cycles -> out_choice 0,1,2,3,0; out_valid=1 each cycle; out_stall of non-granted channels =1.
2. in_ready=0 with in_valid=4'b1010 for 3 cycles -> out_valid=0; out_stall=4'b1010; rr_ptr and wait counters unchanged. Then in_ready=1 -> channel 1 granted.
3. in_flush[1]=1 in cycle 0 only, in_flush_done[1] rises in cycle 3, in_valid=4'b0011 -> out_flush_hold[1]=1 cycles 1-3; ch1 stalled and ungranted cycles 0-3; ch1 eligible again in cycle 4.
4. Mode 1, STARVE_LIMIT=3, in_valid=4'b1001, in_ready=1 -> ch0 granted cycles 0-2; out_starved[3]=1 in cycle 3 and ch3 granted; out_starved[3]=0 in cycle 4 and ch0 wins again.
5. Assert reset for one cycle in the middle of scenario 1 (rr_ptr=2, flush_hold[2]=1) -> during reset out_valid=0 and out_stall=all ones; afterwards rr_ptr=0, holds and counters clear, first grant is ch0.
6. N=2 build, in_valid=2'b11 alternating in_flush[0] each cycle -> ch1 granted whenever ch0 flushed; no grant ever to a channel with flush or hold set.
